// File: rtl/alu_exec_if.sv
// Issue/writeback handshake bundle for the ALU execute unit.
// The issue/writeback side uses the master modport; the unit uses slave.
interface alu_exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal_op;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal_op
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal_op
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit.
// Logic, add/sub and compares complete in one cycle. Shifts run serially,
// SHIFT_STEP bits per cycle. The result is held until writeback takes it.
module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  // One extra bit so that SHIFT_STEP == XLEN is still representable.
  localparam logic [SHW:0] STEP = (SHW + 1)'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            is_shift;
  logic [SHW-1:0]  shamt;
  logic            accept;
  logic [XLEN-1:0] shreg;
  logic [XLEN-1:0] shreg_next;
  logic [SHW-1:0]  cnt;
  logic [SHW-1:0]  cnt_next;
  logic [SHW-1:0]  k;
  logic [1:0]      sh_kind;   // op[1:0] of the latched shift: 00 SRL, 01 SRA, 10 SLL
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            ill_q;

  assign shamt          = bus.b[SHW-1:0];
  assign accept         = bus.in_valid && (state == IDLE);
  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.result     = result_q;
  assign bus.zero       = zero_q;
  assign bus.illegal_op = ill_q;

  // Single-cycle function decode on the live issue inputs.
  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    case (bus.op)
      4'b0000: alu_res = bus.a & bus.b;
      4'b0001: alu_res = bus.a | bus.b;
      4'b0010,
      4'b0110: alu_res = bus.a + bus.b;
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0111: alu_res = bus.a + ~bus.b + 1'b1;
      // Shifts only take this path when shamt is zero, so the result is a.
      4'b1000,
      4'b1001,
      4'b1010: begin
        is_shift = 1'b1;
        alu_res  = bus.a;
      end
      4'b1101: alu_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
      4'b1111: alu_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_ill = 1'b1;
    endcase
  end

  // One serial shift step of k = min(SHIFT_STEP, remaining) bits.
  always_comb begin
    k = ({1'b0, cnt} < STEP) ? cnt : STEP[SHW-1:0];
    case (sh_kind)
      2'b01:   shreg_next = $signed(shreg) >>> k;   // msb of latched a replicates
      2'b10:   shreg_next = shreg << k;
      default: shreg_next = shreg >> k;
    endcase
    cnt_next = cnt - k;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)
                 state_next = (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt_next == '0) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Shift datapath and registered result.
  // NOTE: the shift register and op latch are reset too, so an aborted shift leaves no stale state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      cnt      <= '0;
      sh_kind  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ill_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (is_shift && shamt != '0) begin
          shreg   <= bus.a;
          cnt     <= shamt;
          sh_kind <= bus.op[1:0];
        end else begin
          result_q <= alu_res;
          zero_q   <= (alu_res == '0);
          ill_q    <= alu_ill;
        end
      end else if (state == SHIFT) begin
        shreg <= shreg_next;
        cnt   <= cnt_next;
        if (cnt_next == '0) begin
          result_q <= shreg_next;
          zero_q   <= (shreg_next == '0);
          ill_q    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a vector table for single operations
// on a SHIFT_STEP=1 unit, plus hand sequences for back-pressure, reset
// during a shift and a SHIFT_STEP=4 unit.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_exec_if #(.XLEN(32)) bus1 ();
  alu_exec_if #(.XLEN(32)) bus4 ();

  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op on unit 1, return edges from accept (inclusive) to out_valid.
  task automatic run1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    bus1.op = op; bus1.a = a; bus1.b = b; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    bus1.op = 4'($urandom); bus1.a = $urandom; bus1.b = $urandom;
    lat = 1;
    while (!bus1.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run4(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
    bus4.op = op; bus4.a = a; bus4.b = b; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    bus4.op = 4'($urandom); bus4.a = $urandom; bus4.b = $urandom;
    lat = 1;
    while (!bus4.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain1(input string name);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check({name, ".drain_valid"}, 32'(bus1.out_valid), 32'd0);
    check({name, ".drain_ready"}, 32'(bus1.in_ready), 32'd1);
  endtask

  task automatic drain4();
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  seen;
    string nm;

    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h1,   32'h8000_0000, 1'b0, 1'b0, 1};  // ADD overflow
    vecs[1]  = '{4'b0111, 32'h5,         32'h5,   32'h0,         1'b1, 1'b0, 1};  // SUB to zero
    vecs[2]  = '{4'b1111, 32'hFFFF_FFFF, 32'h1,   32'h1,         1'b0, 1'b0, 1};  // SLT -1<1
    vecs[3]  = '{4'b1101, 32'hFFFF_FFFF, 32'h1,   32'h0,         1'b1, 1'b0, 1};  // SLTU
    vecs[4]  = '{4'b1001, 32'h8000_0000, 32'h4,   32'hF800_0000, 1'b0, 1'b0, 5};  // SRA 4
    vecs[5]  = '{4'b1001, 32'h8000_0000, 32'h0,   32'h8000_0000, 1'b0, 1'b0, 1};  // SRA 0
    vecs[6]  = '{4'b0000, 32'hF0F0,      32'hFF00, 32'hF000,     1'b0, 1'b0, 1};  // AND
    vecs[7]  = '{4'b0001, 32'hF0,        32'h0F,  32'hFF,        1'b0, 1'b0, 1};  // OR
    vecs[8]  = '{4'b0100, 32'hF0,        32'hFF,  32'h0F,        1'b0, 1'b0, 1};  // XOR
    vecs[9]  = '{4'b0110, 32'hFFFF_FFFF, 32'h1,   32'h0,         1'b1, 1'b0, 1};  // ADD wrap
    vecs[10] = '{4'b1000, 32'h8000_0000, 32'd31,  32'h1,         1'b0, 1'b0, 32}; // SRL 31
    vecs[11] = '{4'b1010, 32'h1,         32'h3,   32'h8,         1'b0, 1'b0, 4};  // SLL 3
    vecs[12] = '{4'b1010, 32'h1,         32'd32,  32'h1,         1'b0, 1'b0, 1};  // shamt 32 -> 0
    vecs[13] = '{4'b0011, 32'h1,         32'h1,   32'h0,         1'b1, 1'b1, 1};  // illegal
    vecs[14] = '{4'b0010, 32'h2,         32'h3,   32'h5,         1'b0, 1'b0, 1};  // clears illegal
    vecs[15] = '{4'b1001, 32'h7FFF_FFFF, 32'h2,   32'h1FFF_FFFF, 1'b0, 1'b0, 3};  // SRA positive
    vecs[16] = '{4'b1010, 32'hF,         32'h104, 32'hF0,        1'b0, 1'b0, 5};  // upper b ignored

    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.op = '0; bus1.a = '0; bus1.b = '0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0; bus4.op = '0; bus4.a = '0; bus4.b = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst.in_ready",  32'(bus1.in_ready),   32'd1);
    check("rst.out_valid", 32'(bus1.out_valid),  32'd0);
    check("rst.result",    bus1.result,          32'h0);
    check("rst.zero",      32'(bus1.zero),       32'd1);
    check("rst.illegal",   32'(bus1.illegal_op), 32'd0);

    // Table of single operations.
    for (int i = 0; i < 17; i++) begin
      nm = $sformatf("vec%0d", i);
      run1(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check({nm, ".latency"}, 32'(lat),               32'(vecs[i].lat));
      check({nm, ".result"},  bus1.result,            vecs[i].res);
      check({nm, ".zero"},    32'(bus1.zero),         32'(vecs[i].zero));
      check({nm, ".illegal"}, 32'(bus1.illegal_op),   32'(vecs[i].ill));
      check({nm, ".busy"},    32'(bus1.in_ready),     32'd0);
      drain1(nm);
    end

    // Back-pressure: result held for six cycles, new request ignored.
    run1(4'b0100, 32'hF0, 32'hFF, lat);
    check("bp.latency", 32'(lat), 32'd1);
    bus1.op = 4'b0010; bus1.a = 32'h1; bus1.b = 32'h1; bus1.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", 32'(bus1.out_valid), 32'd1);
      check("bp.in_ready",  32'(bus1.in_ready),  32'd0);
      check("bp.result",    bus1.result,         32'h0F);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("bp.release_valid", 32'(bus1.out_valid), 32'd0);
    check("bp.release_ready", 32'(bus1.in_ready),  32'd1);
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    check("bp.next_valid",  32'(bus1.out_valid), 32'd1);
    check("bp.next_result", bus1.result,         32'h2);
    drain1("bp");

    // Reset pulse in the middle of a long shift.
    bus1.op = 4'b1000; bus1.a = 32'hFFFF_FFFF; bus1.b = 32'd20; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rstmid.shifting", 32'(bus1.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", 32'(bus1.out_valid), 32'd0);
    check("rstmid.in_ready",  32'(bus1.in_ready),  32'd1);
    check("rstmid.result",    bus1.result,         32'h0);
    check("rstmid.zero",      32'(bus1.zero),      32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus1.out_valid) seen = 1'b1;
    end
    check("rstmid.no_result", 32'(seen), 32'd0);

    // Four bits per shift cycle.
    run4(4'b1001, 32'h8000_0000, 32'd5, lat);
    check("step4.b5.latency", 32'(lat),     32'd3);
    check("step4.b5.result",  bus4.result,  32'hFC00_0000);
    drain4();
    run4(4'b1001, 32'h8000_0000, 32'd8, lat);
    check("step4.b8.latency", 32'(lat),     32'd3);
    check("step4.b8.result",  bus4.result,  32'hFF80_0000);
    drain4();
    run4(4'b1010, 32'h1, 32'd3, lat);
    check("step4.b3.latency", 32'(lat),     32'd2);
    check("step4.b3.result",  bus4.result,  32'h8);
    check("step4.b3.zero",    32'(bus4.zero), 32'd0);
    drain4();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
